bam_row_scheduler: RTL and testbench

//  Sequencer for the AL422-to-HUB75E LED datapath. Orders bit-plane row shifts (row r, plane b),

---
 rtl/bam_row_scheduler_pkg.sv | 20 ++
 rtl/bam_oe_timer.sv | 34 +++
 rtl/bam_row_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_bam_row_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bam_row_scheduler_pkg.sv
// rtl/bam_row_scheduler_pkg.sv - shared widths, FSM state encoding and BAM on-time helper
package bam_row_scheduler_pkg;

    localparam int ROW_ADDR_W = 5;
    localparam int BIT_IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_BLANK     = 3'd2,
        ST_LATCH     = 3'd3,
        ST_DISPLAY   = 3'd4
    } sched_state_e;

    // Binary-weighted display time of one plane, before truncation to the counter width.
    function automatic logic [31:0] bam_on_time(input int base, input logic [BIT_IDX_W-1:0] plane);
        return 32'(base) << plane;
    endfunction

endpackage

// File: rtl/bam_oe_timer.sv
// rtl/bam_oe_timer.sv - loadable down-counter timing the blank, latch and display phases
module bam_oe_timer #(
    parameter int WIDTH = 16
) (
    input  logic             in_clk,
    input  logic             in_nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/bam_row_scheduler.sv
// rtl/bam_row_scheduler.sv - orders bit-plane row shifts and drives latch, blanking and BAM OE timing
module bam_row_scheduler
    import bam_row_scheduler_pkg::*;
#(
    parameter int ROW_COUNT      = 8,
    parameter int BIT_PLANES     = 2,
    parameter int BASE_OE_CYCLES = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter int LAT_CYCLES     = 1,
    parameter int OE_CNT_WIDTH   = 16
) (
    input  logic                  in_clk,
    input  logic                  in_nrst,
    input  logic                  enable,
    output logic                  shift_start,
    output logic [ROW_ADDR_W-1:0] shift_row,
    output logic [BIT_IDX_W-1:0]  shift_bit,
    output logic                  frame_start,
    input  logic                  shift_done,
    output logic [ROW_ADDR_W-1:0] led_row,
    output logic                  led_lat,
    output logic                  led_oe,
    output logic                  busy
);

    localparam logic [ROW_ADDR_W-1:0]   LAST_ROW   = ROW_ADDR_W'(ROW_COUNT - 1);
    localparam logic [BIT_IDX_W-1:0]    LAST_BIT   = BIT_IDX_W'(BIT_PLANES - 1);
    localparam logic [OE_CNT_WIDTH-1:0] BLANK_LOAD = OE_CNT_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [OE_CNT_WIDTH-1:0] LAT_LOAD   = OE_CNT_WIDTH'(LAT_CYCLES - 1);

    sched_state_e state_q, state_d;

    logic [ROW_ADDR_W-1:0] ptr_row_q, ptr_row_d;
    logic [BIT_IDX_W-1:0]  ptr_bit_q, ptr_bit_d;
    logic [ROW_ADDR_W-1:0] shift_row_q, shift_row_d;
    logic [BIT_IDX_W-1:0]  shift_bit_q, shift_bit_d;
    logic [ROW_ADDR_W-1:0] led_row_q, led_row_d;
    logic                  pending_q, pending_d;
    logic                  ready_q, ready_d;
    logic                  stopping_q, stopping_d;
    logic                  shift_start_q, shift_start_d;
    logic                  frame_start_q, frame_start_d;

    logic                    tmr_load;
    logic [OE_CNT_WIDTH-1:0] tmr_value;
    logic                    tmr_zero;
    logic [OE_CNT_WIDTH-1:0] disp_load;

    logic halt;
    logic fire;
    logic idle_entry;
    logic ready_clr;
    logic led_row_load;

    // A dropped enable halts immediately; stopping keeps the halt alive if enable bounces back.
    assign halt      = stopping_q | ~enable;
    assign disp_load = OE_CNT_WIDTH'(bam_on_time(BASE_OE_CYCLES, shift_bit_q) - 32'd1);

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        idle_entry   = 1'b0;
        ready_clr    = 1'b0;
        led_row_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !pending_q) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (halt && !pending_q) begin
                    state_d    = ST_IDLE;
                    idle_entry = 1'b1;
                end else if (ready_q) begin
                    state_d      = ST_BLANK;
                    tmr_load     = 1'b1;
                    tmr_value    = BLANK_LOAD;
                    led_row_load = 1'b1;
                end
            end
            ST_BLANK: begin
                if (tmr_zero) begin
                    state_d   = ST_LATCH;
                    tmr_load  = 1'b1;
                    tmr_value = LAT_LOAD;
                end
            end
            ST_LATCH: begin
                if (tmr_zero) begin
                    state_d   = ST_DISPLAY;
                    tmr_load  = 1'b1;
                    tmr_value = disp_load;
                    ready_clr = 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (tmr_zero) begin
                    if (halt) begin
                        state_d    = ST_IDLE;
                        idle_entry = 1'b1;
                    end else if (ready_q) begin
                        state_d      = ST_BLANK;
                        tmr_load     = 1'b1;
                        tmr_value    = BLANK_LOAD;
                        led_row_load = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fire          = enable && !pending_q && !ready_q && !stopping_q;
        ptr_row_d     = ptr_row_q;
        ptr_bit_d     = ptr_bit_q;
        shift_row_d   = shift_row_q;
        shift_bit_d   = shift_bit_q;
        pending_d     = pending_q;
        ready_d       = ready_q;
        stopping_d    = stopping_q;
        shift_start_d = fire;
        frame_start_d = fire && (ptr_row_q == '0) && (ptr_bit_q == '0);
        led_row_d     = led_row_load ? shift_row_q : led_row_q;

        if (fire) begin
            pending_d   = 1'b1;
            shift_row_d = ptr_row_q;
            shift_bit_d = ptr_bit_q;
            if (ptr_bit_q == LAST_BIT) begin
                ptr_bit_d = '0;
                ptr_row_d = (ptr_row_q == LAST_ROW) ? '0 : ptr_row_q + ROW_ADDR_W'(1);
            end else begin
                ptr_bit_d = ptr_bit_q + BIT_IDX_W'(1);
            end
        end

        // A shift finishing after the scheduler went idle must not leave stale data marked ready.
        if (shift_done && pending_q) begin
            pending_d = 1'b0;
            if (state_q != ST_IDLE) begin
                ready_d = 1'b1;
            end
        end
        if (ready_clr) begin
            ready_d = 1'b0;
        end
        if (!enable && state_q != ST_IDLE) begin
            stopping_d = 1'b1;
        end
        if (idle_entry) begin
            ready_d    = 1'b0;
            stopping_d = 1'b0;
            ptr_row_d  = '0;
            ptr_bit_d  = '0;
        end
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q       <= ST_IDLE;
            ptr_row_q     <= '0;
            ptr_bit_q     <= '0;
            shift_row_q   <= '0;
            shift_bit_q   <= '0;
            led_row_q     <= '0;
            pending_q     <= 1'b0;
            ready_q       <= 1'b0;
            stopping_q    <= 1'b0;
            shift_start_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_row_q     <= ptr_row_d;
            ptr_bit_q     <= ptr_bit_d;
            shift_row_q   <= shift_row_d;
            shift_bit_q   <= shift_bit_d;
            led_row_q     <= led_row_d;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
            stopping_q    <= stopping_d;
            shift_start_q <= shift_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    bam_oe_timer #(
        .WIDTH (OE_CNT_WIDTH)
    ) u_timer (
        .in_clk  (in_clk),
        .in_nrst (in_nrst),
        .load    (tmr_load),
        .value   (tmr_value),
        .zero    (tmr_zero)
    );

    assign shift_start = shift_start_q;
    assign frame_start = frame_start_q;
    assign shift_row   = shift_row_q;
    assign shift_bit   = shift_bit_q;
    assign led_row     = led_row_q;
    assign led_lat     = (state_q == ST_LATCH);
    assign led_oe      = (state_q == ST_DISPLAY);
    assign busy        = (state_q != ST_IDLE) || pending_q;

endmodule

// File: tb/tb_bam_row_scheduler.sv
// tb/tb_bam_row_scheduler.sv - directed self-checking bench for bam_row_scheduler
module tb_bam_row_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, en_a, en_b, done_a, done_b, resp_done, spur;
    int   sel = 0;

    logic       ss_a, fs_a, lat_a, oe_a, busy_a;
    logic [4:0] row_a, lrow_a;
    logic [2:0] bit_a;
    logic       ss_b, fs_b, lat_b, oe_b, busy_b;
    logic [4:0] row_b, lrow_b;
    logic [2:0] bit_b;

    logic       m_ss, m_fs, m_lat, m_oe, m_busy, m_done;
    logic [4:0] m_row, m_lrow;
    logic [2:0] m_bit;

    int total = 0;
    int bad   = 0;

    bam_row_scheduler dut_a (
        .in_clk(clk), .in_nrst(nrst), .enable(en_a),
        .shift_start(ss_a), .shift_row(row_a), .shift_bit(bit_a), .frame_start(fs_a),
        .shift_done(done_a), .led_row(lrow_a), .led_lat(lat_a), .led_oe(oe_a), .busy(busy_a)
    );

    bam_row_scheduler #(.BIT_PLANES(8), .BASE_OE_CYCLES(1)) dut_b (
        .in_clk(clk), .in_nrst(nrst), .enable(en_b),
        .shift_start(ss_b), .shift_row(row_b), .shift_bit(bit_b), .frame_start(fs_b),
        .shift_done(done_b), .led_row(lrow_b), .led_lat(lat_b), .led_oe(oe_b), .busy(busy_b)
    );

    assign done_a = (sel == 0) && (resp_done || spur);
    assign done_b = (sel == 1) && (resp_done || spur);
    assign m_ss   = (sel == 0) ? ss_a   : ss_b;
    assign m_fs   = (sel == 0) ? fs_a   : fs_b;
    assign m_lat  = (sel == 0) ? lat_a  : lat_b;
    assign m_oe   = (sel == 0) ? oe_a   : oe_b;
    assign m_busy = (sel == 0) ? busy_a : busy_b;
    assign m_row  = (sel == 0) ? row_a  : row_b;
    assign m_bit  = (sel == 0) ? bit_a  : bit_b;
    assign m_lrow = (sel == 0) ? lrow_a : lrow_b;
    assign m_done = (sel == 0) ? done_a : done_b;

    // Datapath model: answers each shift_start with a one-cycle shift_done 'delay' cycles later.
    int delay = 5;
    int cnt = 0;
    bit resp_en = 1'b0;
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (!resp_en) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) resp_done = 1'b1;
                end
                if (m_ss) cnt = delay;
            end
        end
    end

    int cyc = 0;
    int sh_row[$], sh_bit[$], sh_fs[$], sh_cyc[$];
    int oe_runs[$], lat_runs[$], blank_before[$], lat_lat[$];
    int viol_overlap = 0, viol_row = 0, viol_dbl = 0, viol_fs = 0;
    int oe_run = 0, lat_run = 0, low_run = 0, done_cyc = 0, oe_rises = 0;
    logic prev_oe = 1'b0, prev_lat = 1'b0;
    logic [4:0] prev_row = '0;
    bit outstanding = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (m_lat && m_oe) viol_overlap++;
            if (m_oe && m_lrow != prev_row) viol_row++;
            if (m_fs && !m_ss) viol_fs++;
            if (m_ss) begin
                if (outstanding) viol_dbl++;
                outstanding = 1'b1;
                sh_row.push_back(int'(m_row));
                sh_bit.push_back(int'(m_bit));
                sh_fs.push_back(int'(m_fs));
                sh_cyc.push_back(cyc);
            end
            if (m_done) begin
                outstanding = 1'b0;
                done_cyc = cyc;
            end
            if (m_lat && !prev_lat) begin
                blank_before.push_back(low_run);
                lat_lat.push_back(cyc - done_cyc);
            end
            if (m_oe) begin
                if (!prev_oe) oe_rises++;
                oe_run++;
                low_run = 0;
            end else begin
                if (prev_oe) oe_runs.push_back(oe_run);
                oe_run = 0;
                low_run++;
            end
            if (m_lat) begin
                lat_run++;
            end else begin
                if (prev_lat) lat_runs.push_back(lat_run);
                lat_run = 0;
            end
            prev_oe  = m_oe;
            prev_lat = m_lat;
            prev_row = m_lrow;
        end
    end

    task automatic clear_logs();
        sh_row.delete(); sh_bit.delete(); sh_fs.delete(); sh_cyc.delete();
        oe_runs.delete(); lat_runs.delete(); blank_before.delete(); lat_lat.delete();
        viol_overlap = 0; viol_row = 0; viol_dbl = 0; viol_fs = 0;
        oe_run = 0; lat_run = 0; low_run = 0; oe_rises = 0; done_cyc = cyc;
        prev_oe = 1'b0; prev_lat = 1'b0; prev_row = m_lrow; outstanding = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0; resp_en = 1'b0; en_a = 1'b0; en_b = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        nrst = 1'b0; en_a = 1'b0; en_b = 1'b0; spur = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ss_a !== 1'b0)   begin bad++; $display("FAIL reset_shift_start: got %b want 0", ss_a); end
        total++; if (fs_a !== 1'b0)   begin bad++; $display("FAIL reset_frame_start: got %b want 0", fs_a); end
        total++; if (lat_a !== 1'b0)  begin bad++; $display("FAIL reset_lat: got %b want 0", lat_a); end
        total++; if (oe_a !== 1'b0)   begin bad++; $display("FAIL reset_oe: got %b want 0", oe_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        total++; if (lrow_a !== 5'd0) begin bad++; $display("FAIL reset_led_row: got %0d want 0", lrow_a); end
        total++; if (row_a !== 5'd0 || bit_a !== 3'd0) begin
            bad++; $display("FAIL reset_shift_ptr: got (%0d,%0d) want (0,0)", row_a, bit_a);
        end
    endtask

    task automatic test_order();
        int n;
        int en_cyc;
        do_reset();
        delay = 5; resp_en = 1'b1;
        en_cyc = cyc; en_a = 1'b1;
        n = 0;
        while (sh_row.size() < 17 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (n >= 2000) begin
            bad++; $display("FAIL order_timeout: got %0d shifts want 17", sh_row.size());
        end else begin
            total++;
            if (sh_cyc[0] - en_cyc !== 1) begin
                bad++; $display("FAIL first_shift_latency: got %0d want 1", sh_cyc[0] - en_cyc);
            end
            for (int i = 0; i < 17; i++) begin
                total++;
                if (sh_row[i] !== (i / 2) % 8 || sh_bit[i] !== i % 2 || sh_fs[i] !== int'(i % 16 == 0)) begin
                    bad++;
                    $display("FAIL order_%0d: got (%0d,%0d,fs=%0d) want (%0d,%0d,fs=%0d)", i,
                             sh_row[i], sh_bit[i], sh_fs[i], (i / 2) % 8, i % 2, int'(i % 16 == 0));
                end
            end
        end
    endtask

    task automatic test_display_timing();
        repeat (100) @(negedge clk);
        total++;
        if (oe_runs.size() < 8) begin
            bad++; $display("FAIL oe_run_count: got %0d want >=8", oe_runs.size());
        end
        for (int i = 0; i < oe_runs.size(); i++) begin
            total++;
            if (oe_runs[i] !== ((i % 2 == 1) ? 8 : 4)) begin
                bad++; $display("FAIL oe_run_%0d: got %0d want %0d", i, oe_runs[i], (i % 2 == 1) ? 8 : 4);
            end
        end
        for (int i = 0; i < lat_runs.size(); i++) begin
            total++;
            if (lat_runs[i] !== 1) begin bad++; $display("FAIL lat_width_%0d: got %0d want 1", i, lat_runs[i]); end
        end
        for (int i = 0; i < blank_before.size(); i++) begin
            total++;
            if (blank_before[i] < 2) begin bad++; $display("FAIL blank_guard_%0d: got %0d want >=2", i, blank_before[i]); end
        end
        total++; if (viol_overlap !== 0) begin bad++; $display("FAIL lat_oe_overlap: got %0d want 0", viol_overlap); end
        total++; if (viol_row !== 0)     begin bad++; $display("FAIL row_change_oe: got %0d want 0", viol_row); end
        total++; if (viol_fs !== 0)      begin bad++; $display("FAIL frame_start_alone: got %0d want 0", viol_fs); end
    endtask

    task automatic test_slow_datapath();
        int n;
        do_reset();
        delay = 40; resp_en = 1'b1; en_a = 1'b1;
        n = 0;
        while (sh_row.size() < 6 && n < 2000) begin @(negedge clk); n++; end
        total++; if (n >= 2000) begin bad++; $display("FAIL slow_timeout: got %0d shifts want 6", sh_row.size()); end
        total++; if (viol_dbl !== 0) begin bad++; $display("FAIL slow_double_issue: got %0d want 0", viol_dbl); end
        total++; if (viol_overlap !== 0) begin bad++; $display("FAIL slow_overlap: got %0d want 0", viol_overlap); end
        for (int i = 0; i < lat_lat.size(); i++) begin
            total++;
            if (lat_lat[i] < 1 || lat_lat[i] > 4) begin bad++; $display("FAIL done_to_lat_%0d: got %0d want 1..4", i, lat_lat[i]); end
        end
        for (int i = 1; i < blank_before.size(); i++) begin
            total++;
            if (blank_before[i] < 20) begin bad++; $display("FAIL wait_data_gap_%0d: got %0d want >=20", i, blank_before[i]); end
        end
        for (int i = 0; i < oe_runs.size(); i++) begin
            total++;
            if (oe_runs[i] !== ((i % 2 == 1) ? 8 : 4)) begin
                bad++; $display("FAIL slow_oe_run_%0d: got %0d want %0d", i, oe_runs[i], (i % 2 == 1) ? 8 : 4);
            end
        end
    endtask

    task automatic test_disable();
        int n;
        int en_cyc;
        do_reset();
        delay = 5; resp_en = 1'b1; en_a = 1'b1;
        n = 0;
        while (oe_rises < 2 && n < 500) begin @(negedge clk); n++; end
        total++; if (n >= 500) begin bad++; $display("FAIL disable_reach_plane1: got %0d rises want 2", oe_rises); end
        repeat (2) @(negedge clk);
        en_a = 1'b0;
        n = 0;
        while (busy_a && n < 500) begin @(negedge clk); n++; end
        total++; if (n >= 500) begin bad++; $display("FAIL disable_idle_timeout: got busy=%b want 0", busy_a); end
        repeat (20) @(negedge clk);
        total++; if (oe_runs.size() !== 2) begin bad++; $display("FAIL disable_display_count: got %0d want 2", oe_runs.size()); end
        total++; if (oe_runs.size() >= 2 && oe_runs[1] !== 8) begin bad++; $display("FAIL disable_last_run: got %0d want 8", oe_runs[1]); end
        total++; if (sh_row.size() !== 3) begin bad++; $display("FAIL disable_shift_count: got %0d want 3", sh_row.size()); end
        total++; if (busy_a !== 1'b0 || oe_a !== 1'b0) begin bad++; $display("FAIL disable_idle: got busy=%b oe=%b want 0 0", busy_a, oe_a); end
        clear_logs();
        en_cyc = cyc; en_a = 1'b1;
        n = 0;
        while (sh_row.size() < 1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin
            bad++; $display("FAIL reenable_timeout: got %0d shifts want 1", sh_row.size());
        end else begin
            total++;
            if (sh_row[0] !== 0 || sh_bit[0] !== 0 || sh_fs[0] !== 1 || sh_cyc[0] - en_cyc !== 1) begin
                bad++; $display("FAIL reenable_restart: got (%0d,%0d,fs=%0d,lat=%0d) want (0,0,fs=1,lat=1)",
                                sh_row[0], sh_bit[0], sh_fs[0], sh_cyc[0] - en_cyc);
            end
        end
    endtask

    task automatic test_spurious_and_reset();
        int n;
        do_reset();
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy_a !== 1'b0 || sh_row.size() !== 0) begin
            bad++; $display("FAIL spurious_done_idle: got busy=%b shifts=%0d want 0 0", busy_a, sh_row.size());
        end
        delay = 5; resp_en = 1'b1; en_a = 1'b1;
        n = 0;
        while (sh_row.size() < 1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL spurious_restart_timeout: got %0d want 1", sh_row.size());
        end else begin
            total++;
            if (sh_row[0] !== 0 || sh_bit[0] !== 0 || sh_fs[0] !== 1) begin
                bad++; $display("FAIL spurious_first_shift: got (%0d,%0d,fs=%0d) want (0,0,fs=1)", sh_row[0], sh_bit[0], sh_fs[0]);
            end
        end
        n = 0;
        while (!lat_a && n < 300) begin @(negedge clk); n++; end
        total++; if (n >= 300) begin bad++; $display("FAIL reach_latch_timeout: got lat=%b want 1", lat_a); end
        #2; nrst = 1'b0; #1;
        total++; if (lat_a !== 1'b0)  begin bad++; $display("FAIL async_reset_lat: got %b want 0", lat_a); end
        total++; if (oe_a !== 1'b0)   begin bad++; $display("FAIL async_reset_oe: got %b want 0", oe_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b want 0", busy_a); end
        resp_en = 1'b0; en_a = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        clear_logs();
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy_a !== 1'b0 || oe_a !== 1'b0 || lat_a !== 1'b0) begin
            bad++; $display("FAIL post_reset_done: got busy=%b oe=%b lat=%b want 0 0 0", busy_a, oe_a, lat_a);
        end
    endtask

    task automatic test_eight_planes();
        int n;
        int fs_count;
        sel = 1;
        do_reset();
        delay = 3; resp_en = 1'b1; en_b = 1'b1;
        n = 0;
        while (sh_row.size() < 65 && n < 8000) begin @(negedge clk); n++; end
        total++;
        if (n >= 8000) begin
            bad++; $display("FAIL planes8_timeout: got %0d shifts want 65", sh_row.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (sh_row[i] !== i / 8 || sh_bit[i] !== i % 8) begin
                    bad++; $display("FAIL planes8_order_%0d: got (%0d,%0d) want (%0d,%0d)", i, sh_row[i], sh_bit[i], i / 8, i % 8);
                end
            end
            total++; if (sh_row[63] !== 7 || sh_bit[63] !== 7) begin
                bad++; $display("FAIL planes8_last: got (%0d,%0d) want (7,7)", sh_row[63], sh_bit[63]);
            end
            total++; if (sh_row[64] !== 0 || sh_bit[64] !== 0 || sh_fs[64] !== 1) begin
                bad++; $display("FAIL planes8_wrap: got (%0d,%0d,fs=%0d) want (0,0,fs=1)", sh_row[64], sh_bit[64], sh_fs[64]);
            end
            fs_count = 0;
            foreach (sh_fs[i]) fs_count += sh_fs[i];
            total++; if (fs_count !== 2) begin bad++; $display("FAIL planes8_fs_count: got %0d want 2", fs_count); end
            total++;
            if (oe_runs.size() < 8) begin
                bad++; $display("FAIL planes8_runs: got %0d want >=8", oe_runs.size());
            end else begin
                for (int i = 0; i < 8; i++) begin
                    total++;
                    if (oe_runs[i] !== (1 << i)) begin
                        bad++; $display("FAIL planes8_on_time_%0d: got %0d want %0d", i, oe_runs[i], 1 << i);
                    end
                end
            end
        end
        total++; if (viol_overlap !== 0) begin bad++; $display("FAIL planes8_overlap: got %0d want 0", viol_overlap); end
        en_b = 1'b0;
        sel = 0;
    endtask

    initial begin
        nrst = 1'b0; en_a = 1'b0; en_b = 1'b0; spur = 1'b0;
        test_reset();
        test_order();
        test_display_timing();
        test_slow_datapath();
        test_disable();
        test_spurious_and_reset();
        test_eight_planes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
